// File: rtl/tx_encoder_8b10b.sv
// 8b/10b transmit encoder. Emits one registered 10-bit symbol per enabled byte,
// tracks running disparity across symbols and flags illegal K characters.
module tx_encoder_8b10b #(
    parameter bit INIT_RD = 1'b0
) (
    input  logic       Bit_Rate_CLK_10,
    input  logic       Reset_n,
    input  logic [7:0] TxData,
    input  logic       TxDataK,
    input  logic       Data_En,
    output logic [9:0] TxSymbol,
    output logic       Symbol_Valid,
    output logic       Code_Err,
    output logic       Current_RD
);

    logic       r_rd;
    logic [4:0] w_x;
    logic [2:0] w_y;
    logic       w_kLegal;
    logic [5:0] w_code6;
    logic [3:0] w_code4;
    logic [5:0] w_out6;
    logic [3:0] w_out4;
    logic       w_flip6;
    logic       w_flip4;
    logic       w_rdMid;
    logic       w_rdEnd;
    logic       w_useA7;
    logic [9:0] w_symbol;

    // Sub-block tables hold the RD- form, written in transmission order (a..i, f..j).
    function automatic logic [5:0] code6Minus(input logic [4:0] x);
        case (x)
            5'd0:  code6Minus = 6'b100111;
            5'd1:  code6Minus = 6'b011101;
            5'd2:  code6Minus = 6'b101101;
            5'd3:  code6Minus = 6'b110001;
            5'd4:  code6Minus = 6'b110101;
            5'd5:  code6Minus = 6'b101001;
            5'd6:  code6Minus = 6'b011001;
            5'd7:  code6Minus = 6'b111000;
            5'd8:  code6Minus = 6'b111001;
            5'd9:  code6Minus = 6'b100101;
            5'd10: code6Minus = 6'b010101;
            5'd11: code6Minus = 6'b110100;
            5'd12: code6Minus = 6'b001101;
            5'd13: code6Minus = 6'b101100;
            5'd14: code6Minus = 6'b011100;
            5'd15: code6Minus = 6'b010111;
            5'd16: code6Minus = 6'b011011;
            5'd17: code6Minus = 6'b100011;
            5'd18: code6Minus = 6'b010011;
            5'd19: code6Minus = 6'b110010;
            5'd20: code6Minus = 6'b001011;
            5'd21: code6Minus = 6'b101010;
            5'd22: code6Minus = 6'b011010;
            5'd23: code6Minus = 6'b111010;
            5'd24: code6Minus = 6'b110011;
            5'd25: code6Minus = 6'b100110;
            5'd26: code6Minus = 6'b010110;
            5'd27: code6Minus = 6'b110110;
            5'd28: code6Minus = 6'b001110;
            5'd29: code6Minus = 6'b101110;
            5'd30: code6Minus = 6'b011110;
            default: code6Minus = 6'b101011;
        endcase
    endfunction

    function automatic logic [3:0] code4Minus(input logic [2:0] y);
        case (y)
            3'd0:    code4Minus = 4'b1011;
            3'd1:    code4Minus = 4'b1001;
            3'd2:    code4Minus = 4'b0101;
            3'd3:    code4Minus = 4'b1100;
            3'd4:    code4Minus = 4'b1101;
            3'd5:    code4Minus = 4'b1010;
            3'd6:    code4Minus = 4'b0110;
            default: code4Minus = 4'b1110;
        endcase
    endfunction

    // K 4b forms as sent after an RD- start; the RD+ symbol is the full complement.
    function automatic logic [3:0] k4Minus(input logic [2:0] y);
        case (y)
            3'd0:    k4Minus = 4'b0100;
            3'd1:    k4Minus = 4'b1001;
            3'd2:    k4Minus = 4'b0101;
            3'd3:    k4Minus = 4'b0011;
            3'd4:    k4Minus = 4'b0010;
            3'd5:    k4Minus = 4'b1010;
            3'd6:    k4Minus = 4'b0110;
            default: k4Minus = 4'b1000;
        endcase
    endfunction

    always_comb begin
        w_x      = TxData[4:0];
        w_y      = TxData[7:5];
        w_kLegal = TxDataK && ((w_x == 5'd28) ||
                   ((w_y == 3'd7) && ((w_x == 5'd23) || (w_x == 5'd27) ||
                                      (w_x == 5'd29) || (w_x == 5'd30))));
        w_code6  = (w_kLegal && (w_x == 5'd28)) ? 6'b001111 : code6Minus(w_x);
        w_flip6  = ($countones(w_code6) != 3);
        w_rdMid  = r_rd ^ w_flip6;
        w_useA7  = (!w_rdMid && ((w_x == 5'd17) || (w_x == 5'd18) || (w_x == 5'd20))) ||
                   ( w_rdMid && ((w_x == 5'd11) || (w_x == 5'd13) || (w_x == 5'd14)));
        w_code4  = 4'b0000;
        w_out4   = 4'b0000;
        w_out6   = 6'b000000;
        if (w_kLegal) begin
            w_code4 = k4Minus(w_y);
            w_out6  = r_rd ? ~w_code6 : w_code6;
            w_out4  = r_rd ? ~w_code4 : w_code4;
        end else begin
            w_code4 = ((w_y == 3'd7) && w_useA7) ? 4'b0111 : code4Minus(w_y);
            // D.7 and x.3 are balanced but still pick their form from RD.
            w_out6  = ((w_flip6 || (w_code6 == 6'b111000)) && r_rd) ? ~w_code6 : w_code6;
            w_out4  = ((($countones(w_code4) != 2) || (w_y == 3'd3)) && w_rdMid) ?
                      ~w_code4 : w_code4;
        end
        w_flip4  = ($countones(w_code4) != 2);
        w_rdEnd  = w_rdMid ^ w_flip4;
        w_symbol = {w_out4[0], w_out4[1], w_out4[2], w_out4[3],
                    w_out6[0], w_out6[1], w_out6[2], w_out6[3], w_out6[4], w_out6[5]};
    end

    always_ff @(posedge Bit_Rate_CLK_10) begin
        if (!Reset_n) begin
            TxSymbol     <= 10'd0;
            Symbol_Valid <= 1'b0;
            Code_Err     <= 1'b0;
            r_rd         <= INIT_RD;
        end else if (Data_En) begin
            TxSymbol     <= w_symbol;
            Symbol_Valid <= 1'b1;
            Code_Err     <= TxDataK && !w_kLegal;
            r_rd         <= w_rdEnd;
        end else begin
            TxSymbol     <= 10'd0;
            Symbol_Valid <= 1'b0;
            Code_Err     <= 1'b0;
        end
    end

    assign Current_RD = r_rd;

endmodule

// File: tb/tb_tx_encoder_8b10b.sv
// Self-checking bench for tx_encoder_8b10b: directed vector table with hand-computed
// symbols, then a random D/K stream compared against a disparity-driven reference model.
module tb_tx_encoder_8b10b;

    logic       clock = 1'b0;
    logic       resetN;
    logic [7:0] txData;
    logic       txDataK;
    logic       dataEn;
    logic [9:0] TxSymbol;
    logic       Symbol_Valid;
    logic       Code_Err;
    logic       Current_RD;

    int errorCount = 0;
    int checkCount = 0;

    tx_encoder_8b10b #(.INIT_RD(1'b0)) dut (
        .Bit_Rate_CLK_10 (clock),
        .Reset_n         (resetN),
        .TxData          (txData),
        .TxDataK         (txDataK),
        .Data_En         (dataEn),
        .TxSymbol        (TxSymbol),
        .Symbol_Valid    (Symbol_Valid),
        .Code_Err        (Code_Err),
        .Current_RD      (Current_RD)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       resetN;
        logic       en;
        logic       k;
        logic [7:0] data;
        logic [9:0] expSym;
        logic       expValid;
        logic       expErr;
        logic       expRd;
    } vec_t;

    localparam int NUM_VECS = 22;
    vec_t vecs [NUM_VECS];

    logic [7:0] legalK [12];
    logic [9:0] kTable [12];

    task automatic applyStimulus(input logic rn, input logic en, input logic k, input logic [7:0] d);
        @(negedge clock);
        resetN  = rn;
        dataEn  = en;
        txDataK = k;
        txData  = d;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [9:0] expSym, input logic expValid,
                               input logic expErr, input logic expRd);
        checkCount++;
        if (TxSymbol !== expSym) begin
            errorCount++;
            $display("[TB] FAIL %s.TxSymbol: got 0x%03h expected 0x%03h", name, TxSymbol, expSym);
        end
        checkCount++;
        if (Symbol_Valid !== expValid) begin
            errorCount++;
            $display("[TB] FAIL %s.Symbol_Valid: got %b expected %b", name, Symbol_Valid, expValid);
        end
        checkCount++;
        if (Code_Err !== expErr) begin
            errorCount++;
            $display("[TB] FAIL %s.Code_Err: got %b expected %b", name, Code_Err, expErr);
        end
        checkCount++;
        if (Current_RD !== expRd) begin
            errorCount++;
            $display("[TB] FAIL %s.Current_RD: got %b expected %b", name, Current_RD, expRd);
        end
    endtask

    function automatic logic [5:0] tab6(input logic [4:0] x);
        logic [5:0] t [32] = '{6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001,
                               6'b011001, 6'b111000, 6'b111001, 6'b100101, 6'b010101, 6'b110100,
                               6'b001101, 6'b101100, 6'b011100, 6'b010111, 6'b011011, 6'b100011,
                               6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
                               6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110,
                               6'b011110, 6'b101011};
        return t[x];
    endfunction

    function automatic logic [3:0] tab4(input logic [2:0] y);
        logic [3:0] t [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
        return t[y];
    endfunction

    // Reference: RD- prefers the heavier form, RD+ the lighter; A7 avoids a run of five across e,i,f.
    function automatic void modelEncode(input logic [7:0] d, input logic k, input logic rdIn,
                                        output logic [9:0] sym, output logic err, output logic rdOut);
        logic [9:0] lit;
        logic [5:0] s6;
        logic [3:0] s4;
        logic       rdMid;
        logic       a7;
        int         kIdx;
        kIdx = -1;
        for (int i = 0; i < 12; i++) if (legalK[i] == d) kIdx = i;
        err = 1'b0;
        if (k && kIdx >= 0) begin
            lit = rdIn ? ~kTable[kIdx] : kTable[kIdx];
        end else begin
            err = k;
            s6 = tab6(d[4:0]);
            if (d[4:0] == 5'd7) s6 = rdIn ? 6'b000111 : 6'b111000;
            else if (rdIn && $countones(s6) > 3) s6 = ~s6;
            else if (!rdIn && $countones(s6) < 3) s6 = ~s6;
            rdMid = ($countones(s6) > 3) ? 1'b1 : (($countones(s6) < 3) ? 1'b0 : rdIn);
            if (d[7:5] == 3'd7) begin
                a7 = (!rdMid && s6[1] && s6[0]) || (rdMid && !s6[1] && !s6[0]);
                if (a7) s4 = rdMid ? 4'b1000 : 4'b0111;
                else    s4 = rdMid ? 4'b0001 : 4'b1110;
            end else if (d[7:5] == 3'd3) begin
                s4 = rdMid ? 4'b0011 : 4'b1100;
            end else begin
                s4 = tab4(d[7:5]);
                if (rdMid && $countones(s4) > 2) s4 = ~s4;
                else if (!rdMid && $countones(s4) < 2) s4 = ~s4;
            end
            lit = {s6, s4};
        end
        rdOut = ($countones(lit) > 5) ? 1'b1 : (($countones(lit) < 5) ? 1'b0 : rdIn);
        for (int b = 0; b < 10; b++) sym[b] = lit[9 - b];
    endfunction

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached before the summary");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [9:0] mSym;
        logic       mErr;
        logic       mRd;
        logic       nextRd;
        logic [7:0] d;
        logic       k;
        logic       en;
        int         runSum;
        int         maxDrift;

        legalK = '{8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC, 8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE};
        kTable = '{10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011,
                   10'b0011110010, 10'b0011111010, 10'b0011110110, 10'b0011111000,
                   10'b1110101000, 10'b1101101000, 10'b1011101000, 10'b0111101000};

        //              rstN  en    k     data   expSym   vld   err   rd
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 8'h00, 10'h0B9, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 8'hBC, 10'h17C, 1'b1, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 8'hBC, 10'h283, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 8'h00, 10'h0B9, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 8'hBC, 10'h17C, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 8'hBC, 10'h000, 1'b0, 1'b0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 1'b0, 8'h55, 10'h000, 1'b0, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 8'h00, 10'h000, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{1'b1, 1'b1, 1'b1, 8'hBC, 10'h283, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 8'hF1, 10'h3B1, 1'b1, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 8'hBC, 10'h000, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'hBC, 10'h17C, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 8'h00, 10'h346, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 8'hE7, 10'h238, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 8'hEB, 10'h1CB, 1'b1, 1'b0, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 1'b0, 8'hEB, 10'h04B, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 8'hFC, 10'h07C, 1'b1, 1'b0, 1'b0};
        vecs[18] = '{1'b1, 1'b1, 1'b1, 8'hF7, 10'h057, 1'b1, 1'b0, 1'b0};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 8'h63, 10'h0E3, 1'b1, 1'b0, 1'b0};
        vecs[20] = '{1'b1, 1'b1, 1'b1, 8'h1C, 10'h0BC, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{1'b1, 1'b1, 1'b1, 8'hFF, 10'h235, 1'b1, 1'b1, 1'b0};

        resetN  = 1'b0;
        dataEn  = 1'b0;
        txDataK = 1'b0;
        txData  = 8'h00;
        repeat (2) @(posedge clock);

        for (int i = 0; i < NUM_VECS; i++) begin
            applyStimulus(vecs[i].resetN, vecs[i].en, vecs[i].k, vecs[i].data);
            checkOutput($sformatf("vec%0d", i), vecs[i].expSym, vecs[i].expValid,
                        vecs[i].expErr, vecs[i].expRd);
        end

        // Random stream from a fresh reset, with a running-disparity bound on the DUT output.
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        checkOutput("rndReset", 10'h000, 1'b0, 1'b0, 1'b0);
        mRd      = 1'b0;
        runSum   = -1;
        maxDrift = 1;
        for (int i = 0; i < 1000; i++) begin
            en = ($urandom_range(0, 9) != 0);
            k  = ($urandom_range(0, 4) == 0);
            if (k && $urandom_range(0, 3) != 0) d = legalK[$urandom_range(0, 11)];
            else d = 8'($urandom_range(0, 255));
            applyStimulus(1'b1, en, k, d);
            if (en) begin
                modelEncode(d, k, mRd, mSym, mErr, nextRd);
                mRd = nextRd;
                checkOutput($sformatf("rnd%0d", i), mSym, 1'b1, mErr, mRd);
                runSum += 2 * $countones(TxSymbol) - 10;
                if (runSum > maxDrift) maxDrift = runSum;
                if (-runSum > maxDrift) maxDrift = -runSum;
            end else begin
                checkOutput($sformatf("rnd%0d", i), 10'h000, 1'b0, 1'b0, mRd);
            end
        end
        checkCount++;
        if (maxDrift > 1) begin
            errorCount++;
            $display("[TB] FAIL rdDrift: got max |disparity| %0d expected at most 1", maxDrift);
        end

        $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
        $finish;
    end

endmodule

// File: doc/tx_encoder_8b10b.md
Name: tx_encoder_8b10b

Overview:
- Transmit-path 8b/10b encoder, directly downstream of the PIPE TX byte gasket; consumes its TxData/TxDataK byte stream at Bit_Rate_CLK_10.
- Produces one registered 10-bit symbol per enabled byte and maintains running disparity (RD).
- Feeds the 10:1 serializer, which transmits bit 0 first.
- Flags illegal control characters.

Parameters:
- INIT_RD, 0, RD value after reset (0 = RD-, 1 = RD+).

Ports:
- Bit_Rate_CLK_10  input  1  symbol clock (bit rate / 10)
- Reset_n  input  1  reset, synchronous, active-low
- TxData  input  8  byte to encode, {H,G,F,E,D,C,B,A}, A = bit 0
- TxDataK  input  1  1 = control (K) character, 0 = data (D)
- Data_En  input  1  byte valid this cycle
- TxSymbol  output  10  encoded symbol {j,h,g,f,i,e,d,c,b,a}, a = bit 0, transmitted first
- Symbol_Valid  output  1  TxSymbol holds a new symbol
- Code_Err  output  1  TxDataK=1 with an illegal K value (one-cycle pulse)
- Current_RD  output  1  running disparity after the last encoded symbol

Behaviour:
- Single clock domain. Reset_n is sampled only on the rising edge of Bit_Rate_CLK_10; the reset branch overrides all other inputs.
- Reset values:
  - TxSymbol = 0, Symbol_Valid = 0, Code_Err = 0.
  - RD register = INIT_RD; Current_RD = INIT_RD.
- Latency: inputs sampled at edge N; TxSymbol, Symbol_Valid, Code_Err and Current_RD update at edge N.
  - Exactly one register stage; the encode logic is combinational ahead of it.
- Data_En = 0 at an edge:
  - Symbol_Valid <= 0, Code_Err <= 0.
  - TxSymbol <= 0; RD unchanged.
- Data_En = 1: encode with the current RD and register the result.
- 5b/6b stage: EDCBA -> abcdei per the standard 8b/10b table.
  - If the 6b disparity is nonzero, the complement (RD+) form is used when RD = +.
  - The stage's intermediate RD flips on a nonzero-disparity sub-block.
  - D.7 (111000/000111) is treated as non-neutral for coding selection; RD does not flip.
- 3b/4b stage: HGF -> fghj using the intermediate RD.
  - Same complement and flip rules as the 5b/6b stage.
  - x.3 (0011/1100) selects on RD; RD does not flip.
- D.x.7 uses A7 (RD- 0111, RD+ 1000) when RD- and x in {17,18,20}, or RD+ and x in {11,13,14}; otherwise P7 (1110/0001).
- Legal K codes: K28.0–K28.7 (0x1C, 0x3C, …, 0xFC), K23.7 (0xF7), K27.7 (0xFB), K29.7 (0xFD), K30.7 (0xFE).
  - K28.y 6b = 001111 at RD-, 110000 at RD+.
  - K.x.7 always uses A7.
  - K28.1, K28.5 and K28.7 use the inverted 3b/4b forms so the comma appears.
- Illegal K (TxDataK = 1, byte not in the legal list):
  - Byte encoded as D; Code_Err = 1 for that cycle.
  - Symbol_Valid = 1; RD updates as for the D code.
- RD register <= final RD after the 4b sub-block. Current_RD mirrors the RD register.
- Reset mid-stream: the next edge with Reset_n = 0 forces the reset values regardless of Data_En. Encoding resumes at INIT_RD on the first enabled byte after release.
- Back-to-back enabled bytes: every cycle uses the RD produced by the previous cycle. There are no bubbles and no stall path.

Test Plan:
1. Reset, INIT_RD = 0; Data_En = 1, TxData = 0x00, TxDataK = 0 -> TxSymbol = 0x0B9 (100111 0100) one edge later; Symbol_Valid = 1, Current_RD = 0.
2. From RD-, K28.5 (0xBC, K = 1), then K28.5 again -> TxSymbol 0x17C with Current_RD = 1, then 0x283 with Current_RD = 0; Code_Err = 0 throughout.
3. From RD-, D17.7 (0xF1, K = 0) -> TxSymbol = 0x3B1 (A7 selected), Current_RD = 1.
4. TxDataK = 1, TxData = 0x00 -> Code_Err = 1 for exactly one cycle; TxSymbol = 0x0B9, Symbol_Valid = 1; next byte K28.5 clears Code_Err.
5. Data_En = 0 for 3 cycles between K28.5 bytes -> Symbol_Valid = 0, TxSymbol = 0, Current_RD holds 1; the next K28.5 encodes as 0x283.
6. Reset_n = 0 for one edge while RD = + and Data_En = 1 -> all outputs 0 and Current_RD = 0 at that edge; the first K28.5 after release = 0x17C. Also compare a 1000-byte random D/K stream against a reference-model encoder: zero mismatches, |RD drift| ≤ 1.
